// File: rtl/cmp_pkg.sv
// Shared types for the glyph compare accelerator.
//   - cnt_w():   width needed to hold a count 0..n inclusive
//   - state_e:   bbox scanner FSM states
//   - result_t:  packed bounding-box result record
// The struct field widths follow the default W/H below. A scanner built with
// other W/H values must have these defaults updated to match.
package cmp_pkg;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int DEF_W  = 64;
  localparam int DEF_H  = 24;
  localparam int DEF_CW = cnt_w(DEF_W);
  localparam int DEF_RW = cnt_w(DEF_H);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    ENCODE,
    DONE
  } state_e;

  typedef struct packed {
    logic [DEF_CW-1:0] lshift;
    logic [DEF_CW-1:0] rshift;
    logic [DEF_RW-1:0] ushift;
    logic [DEF_RW-1:0] dshift;
    logic              scale_h;
    logic              scale_v;
    logic              blank;
    logic              err;
  } result_t;

endpackage

// File: rtl/bbox_penc.sv
// Leading/trailing zero counter over a W-bit vector.
//   vec : input vector, bit 0 = leftmost column
//   tz  : zeros counted upward from bit 0 (W when vec is all zero)
//   lz  : zeros counted downward from bit W-1 (W when vec is all zero)
module bbox_penc #(
  parameter  int W  = 64,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] tz,
  output logic [CW-1:0] lz
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise synthesis infers a latch.
  always_comb begin
    tz = CW'(W);
    lz = CW'(W);
    // Scanning from the far end lets the last hit (the nearest set bit) win.
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) tz = CW'(i);
    end
    for (int i = 0; i < W; i++) begin
      if (vec[i]) lz = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/glyph_bbox_scan.sv
// Glyph bitmap bounding-box analyser.
// Accepts one W x H bitmap as a row stream, measures the empty margin on all
// four sides and reports shifts, 2x scale flags, blank and error flags.
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : one-cycle pulse, aborts any bitmap and begins a new one
//   row_data/valid/last : row stream in; row_ready high while scanning
//   res_*               : result fields, stable while res_valid is high
//   res_valid/res_ready : result handshake
module glyph_bbox_scan
  import cmp_pkg::*;
#(
  parameter  int W         = DEF_W,
  parameter  int H         = DEF_H,
  parameter  int HSCALE_TH = 12,
  parameter  int VSCALE_TH = 12,
  localparam int CW        = cnt_w(W),
  localparam int RW        = cnt_w(H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  row_data,
  input  logic          row_valid,
  input  logic          row_last,
  output logic          row_ready,
  output logic [CW-1:0] res_lshift,
  output logic [CW-1:0] res_rshift,
  output logic [RW-1:0] res_ushift,
  output logic [RW-1:0] res_dshift,
  output logic          res_scale_h,
  output logic          res_scale_v,
  output logic          res_blank,
  output logic          res_err,
  output logic          res_valid,
  input  logic          res_ready
);

  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  col_or_q, col_or_d;
  logic [RW-1:0] top_q, top_d;       // empty rows above the first inked row
  logic [RW-1:0] trail_q, trail_d;   // empty rows since the last inked row
  logic [RW-1:0] cnt_q, cnt_d;       // rows accepted so far
  logic          seen_q, seen_d;     // an inked row has been seen
  logic          err_q, err_d;       // row_last and H-th row disagreed
  result_t       res_q, res_d;

  logic [CW-1:0] tz, lz;
  logic          row_acc;
  logic          row_ink;
  logic [RW:0]   dshift_full;
  logic [RW:0]   vsum;
  logic [CW:0]   hsum;

  bbox_penc #(.W(W)) u_penc (
    .vec (col_or_q),
    .tz  (tz),
    .lz  (lz)
  );

  assign row_ready = (state_q == SCAN);
  // start takes priority over a row presented in the same cycle.
  assign row_acc   = row_valid && row_ready && !start;
  assign row_ink   = |row_data;

  // Rows never delivered after an early row_last count as empty bottom rows.
  assign dshift_full = {1'b0, trail_q} + (RW + 1)'(H) - {1'b0, cnt_q};
  assign vsum        = {1'b0, top_q} + dshift_full;
  assign hsum        = {1'b0, tz} + {1'b0, lz};

  always_comb begin
    state_d  = state_q;
    col_or_d = col_or_q;
    top_d    = top_q;
    trail_d  = trail_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    err_d    = err_q;
    res_d    = res_q;

    unique case (state_q)
      IDLE: ;
      SCAN: begin
        if (row_acc) begin
          col_or_d = col_or_q | row_data;
          if (!seen_q) begin
            if (row_ink) seen_d = 1'b1;
            else         top_d  = top_q + ROW_ONE;
          end
          trail_d = row_ink ? '0 : trail_q + ROW_ONE;
          cnt_d   = cnt_q + ROW_ONE;
          if (row_last || cnt_q == ROW_LAST) begin
            err_d   = row_last != (cnt_q == ROW_LAST);
            state_d = ENCODE;
          end
        end
      end
      ENCODE: begin
        res_d = '0;
        res_d.err = err_q;
        if (col_or_q == '0) begin
          res_d.blank = 1'b1;
        end else begin
          res_d.lshift  = tz;
          res_d.rshift  = lz;
          res_d.ushift  = top_q;
          res_d.dshift  = dshift_full[RW-1:0];
          res_d.scale_h = hsum >= (CW + 1)'(HSCALE_TH);
          res_d.scale_v = vsum >= (RW + 1)'(VSCALE_TH);
        end
        state_d = DONE;
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d  = SCAN;
      col_or_d = '0;
      top_d    = '0;
      trail_d  = '0;
      cnt_d    = '0;
      seen_d   = 1'b0;
      err_d    = 1'b0;
      res_d    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, and the reset
  // is sampled inside the clocked block, so it acts synchronously.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      col_or_q <= '0;
      top_q    <= '0;
      trail_q  <= '0;
      cnt_q    <= '0;
      seen_q   <= 1'b0;
      err_q    <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      col_or_q <= col_or_d;
      top_q    <= top_d;
      trail_q  <= trail_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      err_q    <= err_d;
      res_q    <= res_d;
    end
  end

  assign res_valid   = (state_q == DONE);
  assign res_lshift  = res_q.lshift;
  assign res_rshift  = res_q.rshift;
  assign res_ushift  = res_q.ushift;
  assign res_dshift  = res_q.dshift;
  assign res_scale_h = res_q.scale_h;
  assign res_scale_v = res_q.scale_v;
  assign res_blank   = res_q.blank;
  assign res_err     = res_q.err;

endmodule

// File: tb/tb_glyph_bbox_scan.sv
// Directed bench for glyph_bbox_scan (W=64, H=24).
module tb_glyph_bbox_scan;

  localparam int W  = 64;
  localparam int H  = 24;
  localparam int CW = 7;
  localparam int RW = 5;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  row_data;
  logic          row_valid;
  logic          row_last;
  logic          row_ready;
  logic [CW-1:0] res_lshift;
  logic [CW-1:0] res_rshift;
  logic [RW-1:0] res_ushift;
  logic [RW-1:0] res_dshift;
  logic          res_scale_h;
  logic          res_scale_v;
  logic          res_blank;
  logic          res_err;
  logic          res_valid;
  logic          res_ready;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] bm [H];

  glyph_bbox_scan #(.W(W), .H(H), .HSCALE_TH(12), .VSCALE_TH(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .row_data    (row_data),
    .row_valid   (row_valid),
    .row_last    (row_last),
    .row_ready   (row_ready),
    .res_lshift  (res_lshift),
    .res_rshift  (res_rshift),
    .res_ushift  (res_ushift),
    .res_dshift  (res_dshift),
    .res_scale_h (res_scale_h),
    .res_scale_v (res_scale_v),
    .res_blank   (res_blank),
    .res_err     (res_err),
    .res_valid   (res_valid),
    .res_ready   (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bm();
    for (int i = 0; i < H; i++) bm[i] = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Streams bm[0..n-1]; row_last flags row n-1 when use_last is set.
  task automatic send_rows(input int n, input bit use_last);
    for (int r = 0; r < n; r++) begin
      row_valid = 1'b1;
      row_data  = bm[r];
      row_last  = use_last && (r == n - 1);
      tick();
    end
    row_valid = 1'b0;
    row_last  = 1'b0;
    row_data  = '0;
  endtask

  // One ENCODE cycle with res_valid low, then DONE.
  task automatic wait_result(input string tag);
    check({tag, ".enc_valid"}, 64'(res_valid), 64'd0);
    tick();
    check({tag, ".done_valid"}, 64'(res_valid), 64'd1);
    check({tag, ".done_rdy"}, 64'(row_ready), 64'd0);
  endtask

  task automatic check_res(input string tag, input int l, input int r, input int u,
                           input int d, input bit sh, input bit sv, input bit b,
                           input bit e);
    check({tag, ".lshift"},  64'(res_lshift),  64'(l));
    check({tag, ".rshift"},  64'(res_rshift),  64'(r));
    check({tag, ".ushift"},  64'(res_ushift),  64'(u));
    check({tag, ".dshift"},  64'(res_dshift),  64'(d));
    check({tag, ".scale_h"}, 64'(res_scale_h), 64'(sh));
    check({tag, ".scale_v"}, 64'(res_scale_v), 64'(sv));
    check({tag, ".blank"},   64'(res_blank),   64'(b));
    check({tag, ".err"},     64'(res_err),     64'(e));
  endtask

  task automatic accept();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; row_data = '0; row_valid = 1'b0;
    row_last = 1'b0; res_ready = 1'b0;
    clear_bm();

    // Reset state
    tick(); tick();
    check("rst.row_ready", 64'(row_ready), 64'd0);
    check("rst.res_valid", 64'(res_valid), 64'd0);
    check_res("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    check("idle.row_ready", 64'(row_ready), 64'd0);

    // T1: clean box, columns 5..40, rows 3..20
    clear_bm();
    for (int i = 3; i <= 20; i++) bm[i] = (64'd1 << 5) | (64'd1 << 40);
    do_start();
    check("t1.row_ready", 64'(row_ready), 64'd1);
    send_rows(24, 1'b1);
    wait_result("t1");
    check_res("t1", 5, 23, 3, 3, 1, 0, 0, 0);
    accept();
    check("t1.acc_valid", 64'(res_valid), 64'd0);

    // T2: blank bitmap; result left pending, then start from DONE
    clear_bm();
    do_start();
    send_rows(24, 1'b1);
    wait_result("t2");
    check_res("t2", 0, 0, 0, 0, 0, 0, 1, 0);
    tick(); tick();
    check("t2.pend_valid", 64'(res_valid), 64'd1);
    do_start();
    check("t2.restart_valid", 64'(res_valid), 64'd0);
    check("t2.restart_rdy", 64'(row_ready), 64'd1);
    check("t2.restart_blank", 64'(res_blank), 64'd0);

    // T3: early row_last on row 15 (already scanning)
    clear_bm();
    for (int i = 10; i <= 15; i++) bm[i] = 64'd1;
    send_rows(16, 1'b1);
    wait_result("t3");
    check_res("t3", 0, 63, 10, 8, 1, 1, 0, 1);
    accept();

    // T4: abort at row 12, start cycle carries an ignored row, then clean bitmap
    for (int i = 0; i < H; i++) bm[i] = 64'd1 << 10;
    do_start();
    send_rows(12, 1'b0);
    start = 1'b1; row_valid = 1'b1; row_data = '1;
    tick();
    start = 1'b0; row_valid = 1'b0; row_data = '0;
    clear_bm();
    bm[23] = 64'd1 << 63;
    send_rows(24, 1'b1);
    wait_result("t4");
    check_res("t4", 63, 0, 23, 0, 1, 1, 0, 0);

    // T5: backpressure for 10 cycles, fields stay put
    for (int c = 0; c < 10; c++) begin
      tick();
      check("t5.hold_valid",  64'(res_valid),  64'd1);
      check("t5.hold_rdy",    64'(row_ready),  64'd0);
      check("t5.hold_lshift", 64'(res_lshift), 64'd63);
      check("t5.hold_ushift", 64'(res_ushift), 64'd23);
    end
    accept();
    check("t5.acc_valid", 64'(res_valid), 64'd0);
    check("t5.keep_lshift", 64'(res_lshift), 64'd63);

    // T6: reset mid-scan, rows ignored until next start
    for (int i = 0; i < H; i++) bm[i] = 64'd1 << 7;
    do_start();
    send_rows(5, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6.rst_rdy", 64'(row_ready), 64'd0);
    check("t6.rst_valid", 64'(res_valid), 64'd0);
    check_res("t6.rst", 0, 0, 0, 0, 0, 0, 0, 0);
    row_valid = 1'b1; row_data = '1; row_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t6.idle_rdy", 64'(row_ready), 64'd0);
      check("t6.idle_valid", 64'(res_valid), 64'd0);
    end
    row_valid = 1'b0; row_data = '0; row_last = 1'b0;
    clear_bm();
    bm[5] = 64'd1 << 2;
    do_start();
    send_rows(24, 1'b1);
    wait_result("t6");
    check_res("t6", 2, 61, 5, 18, 1, 1, 0, 0);
    accept();

    // T7: start together with reset -> reset wins
    rst_n = 1'b0; start = 1'b1;
    tick();
    rst_n = 1'b1; start = 1'b0;
    check("t7.rdy", 64'(row_ready), 64'd0);
    check("t7.valid", 64'(res_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
